regfile_sb: RTL

- Parametrised successor to the CPU general/special register file: N entries of DATA_W bits, two bypassed read ports and one write port.
- Adds a per-entry busy scoreboard. ID reserves a destination at issue; MEM/WB releases it at writeback.
- Adds a post-reset initialisation sweep FSM, so the storage array can map to distributed RAM.
- Sits between ID (reads, issue) and MEM/WB (writeback); drives the board LED debug output.

---
 rtl/regfile_sb.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Register file with a per-entry busy scoreboard and a post-reset init sweep.
// Latency: reads and busy flags are combinational, with writeback bypass; writes land on the next rising edge.
// Backpressure: none. Callers hold off until ready=1; while the sweep runs, writes, issues and flushes are ignored.
//
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   re1/reg1Addr, re2/reg2Addr     read ports (ID)
//   reg1Data/reg1Busy,
//   reg2Data/reg2Busy              operand data and operand-not-ready flags
//   we/regAddr/regData             writeback (MEM/WB); also releases the busy bit
//   issueEn/issueAddr              destination reservation at issue (ID)
//   flush                          clears every busy bit
//   ready                          registered; high once the init sweep has finished
//   led                            mirror of entry LED_INDEX for board debug
module regfile_sb #(
    parameter int                 DATA_W    = 16,
    parameter int                 NUM_REGS  = 12,
    parameter int                 ADDR_W    = 4,
    parameter int                 SP_INDEX  = 8,
    parameter logic [DATA_W-1:0]  SP_RESET  = 16'hfe00,
    parameter int                 LED_INDEX = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] reg1Addr,
    input  logic [ADDR_W-1:0] reg2Addr,
    input  logic              we,
    input  logic [ADDR_W-1:0] regAddr,
    input  logic [DATA_W-1:0] regData,
    input  logic              issueEn,
    input  logic [ADDR_W-1:0] issueAddr,
    input  logic              flush,
    output logic [DATA_W-1:0] reg1Data,
    output logic [DATA_W-1:0] reg2Data,
    output logic              reg1Busy,
    output logic              reg2Busy,
    output logic              ready,
    output logic [DATA_W-1:0] led
);

    typedef enum logic {INIT, RUN} state_t;

    // One extra bit so the range check still works when NUM_REGS == 2^ADDR_W.
    localparam logic [ADDR_W:0]   NREGS    = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] SP_IDX   = ADDR_W'(SP_INDEX);

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;

    // Storage carries no reset so it can map onto distributed RAM; the sweep
    // provides the initial contents instead.
    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NREGS;
    endfunction

    // Single write port shared between the init sweep and writeback.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = cnt;
        mem_wd = '0;
        if (rst) begin
            if (state == INIT) begin
                mem_we = 1'b1;
                mem_wa = cnt;
                mem_wd = (cnt == SP_IDX) ? SP_RESET : '0;
            end else if (we && in_range(regAddr)) begin
                mem_we = 1'b1;
                mem_wa = regAddr;
                mem_wd = regData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Scoreboard next state: flush beats everything; otherwise the writeback
    // clear is applied before the issue set, so a same-entry issue wins.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (we && in_range(regAddr)) begin
                busy_nxt[regAddr] = 1'b0;
            end
            if (issueEn && in_range(issueAddr)) begin
                busy_nxt[issueAddr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= INIT;
            cnt   <= '0;
            busy  <= '0;
            ready <= 1'b0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end else begin
            busy <= busy_nxt;
        end
    end

    // Read port 1: out-of-range addresses read 0 and never take the bypass.
    always_comb begin
        reg1Data = '0;
        reg1Busy = 1'b0;
        if (state == RUN && re1 && in_range(reg1Addr)) begin
            if (we && regAddr == reg1Addr) begin
                reg1Data = regData;
            end else begin
                reg1Data = mem[reg1Addr];
                reg1Busy = busy[reg1Addr];
            end
        end
    end

    // Read port 2, identical to port 1.
    always_comb begin
        reg2Data = '0;
        reg2Busy = 1'b0;
        if (state == RUN && re2 && in_range(reg2Addr)) begin
            if (we && regAddr == reg2Addr) begin
                reg2Data = regData;
            end else begin
                reg2Data = mem[reg2Addr];
                reg2Busy = busy[reg2Addr];
            end
        end
    end

    // LED shows stored contents only; a write appears the cycle after its edge.
    assign led = (state == RUN) ? mem[LED_INDEX] : '0;

endmodule
